// File: rtl/mux_pkg.sv
// Shared constants and lock-state encoding for the rr_mux41 slice.
// Packet lock feature is enabled with RR_MUX_LOCK_EN.
package mux_pkg;

    localparam int LANES  = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter.
// Searches ptr, ptr+1, ptr+2, ptr+3 (mod 4) and grants the first requester.
module rr_arb4
    import mux_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [LANES-1:0] gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux41.sv
// Four-lane round-robin merge into one registered, lane-tagged stream.
// Define RR_MUX_LOCK_EN to add in_last/out_last and packet locking.
module rr_mux41
    import mux_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LANES*W-1:0] in_data,
    input  logic [LANES-1:0]   in_valid,
    output logic [LANES-1:0]   in_ready,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
`ifdef RR_MUX_LOCK_EN
    ,
    input  logic [LANES-1:0]   in_last,
    output logic               out_last
`endif
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [LANES-1:0] req, gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             can_load;
    logic             push;

`ifdef RR_MUX_LOCK_EN
    lock_st_e         state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic             last_q, last_d;

    // While locked only the owning lane may compete.
    always_comb begin
        req = in_valid;
        if (state_q == ST_LOCKED) begin
            req = in_valid & (LANES'(1) << lock_q);
        end
    end
`else
    assign req = in_valid;
`endif

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign can_load = rst_n & (~valid_q | out_ready);
    assign push     = can_load & (|gnt);
    assign in_ready = can_load ? gnt : '0;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (push) begin
            data_d  = in_data[gnt_idx*W +: W];
            sel_d   = gnt_idx;
            valid_d = 1'b1;
`ifdef RR_MUX_LOCK_EN
            if (in_last[gnt_idx]) begin
                ptr_d = gnt_idx + 2'd1;
            end
`else
            ptr_d   = gnt_idx + 2'd1;
`endif
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        last_d  = last_q;
        if (push) begin
            last_d = in_last[gnt_idx];
            unique case (state_q)
                ST_IDLE: begin
                    if (!in_last[gnt_idx]) begin
                        state_d = ST_LOCKED;
                        lock_d  = gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (in_last[gnt_idx]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
        end
    end

    assign out_last = last_q;
`endif

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
